// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: pipeline-boundary structs,
// memToReg codes and the pixel-access FSM state.
package mem_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_DMEM = 2'b01;
  localparam logic [1:0] MTR_PIX  = 2'b10;
  localparam logic [1:0] MTR_TRIG = 2'b11;

  typedef enum logic {MEM_IDLE = 1'b0, MEM_PIX_BUSY = 1'b1} mem_state_t;

  typedef struct packed {
    logic       regWrite;
    logic       pcSrc;
    logic [1:0] memToReg;
    logic       memWrite;
    logic       memPixWrite;
  } exe_mem_cu_signals;

  typedef struct packed {
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] R1;
    logic [XLEN-1:0] trigResult;
  } exe_mem_interface;

  typedef struct packed {
    logic       regWrite;
    logic       pcSrc;
    logic [1:0] memToReg;
  } mem_wb_cu_signals;

  typedef struct packed {
    logic [XLEN-1:0] aluResult;
    logic [XLEN-1:0] dataMemRead;
    logic [XLEN-1:0] pixMemRead;
    logic [XLEN-1:0] trigResult;
  } mem_wb_interface;

  // A pixel access is either a pixel store or a load whose result comes from pixel memory.
  function automatic logic is_pixel_op(input exe_mem_cu_signals cu);
    return cu.memPixWrite || (cu.memToReg == MTR_PIX);
  endfunction

endpackage

// File: rtl/mem_stage_data_mem.sv
// Single-port synchronous data RAM with registered read (read-before-write).
// Array contents are deliberately not reset; only the read register is.
module data_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // storage array write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // read register samples the pre-write contents of the addressed word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'd0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: data RAM access, req/ack pixel port with
// upstream stall, and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_DEPTH = 1024,
  parameter int PIX_AW     = 19,
  parameter int PIX_DW     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  exe_mem_cu_signals exe_cu,
  input  exe_mem_interface  exe_data,
  output logic              mem_stall,
  output logic              wb_valid,
  output mem_wb_cu_signals  wb_cu,
  output mem_wb_interface   wb_data,
  output logic              pix_req,
  output logic              pix_we,
  output logic [PIX_AW-1:0] pix_addr,
  output logic [PIX_DW-1:0] pix_wdata,
  input  logic [PIX_DW-1:0] pix_rdata,
  input  logic              pix_ack
);

  localparam int DM_AW = $clog2(DMEM_DEPTH);

  mem_state_t        state_q, state_d;
  logic              pix_req_q, pix_req_d;
  logic              pix_we_q, pix_we_d;
  logic [PIX_AW-1:0] pix_addr_q, pix_addr_d;
  logic [PIX_DW-1:0] pix_wdata_q, pix_wdata_d;

  logic              wb_valid_q, wb_valid_d;
  mem_wb_cu_signals  wb_cu_q, wb_cu_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic [XLEN-1:0]   trig_q, trig_d;
  logic [XLEN-1:0]   pix_rd_q, pix_rd_d;

  logic              pix_op_s;
  logic              ack_s;
  logic              dm_we_s;
  logic [XLEN-1:0]   dm_rdata_s;

  assign pix_op_s = in_valid && is_pixel_op(exe_cu);
  assign ack_s    = (state_q == MEM_PIX_BUSY) && pix_ack;

  // pixel FSM next state, port next values and upstream stall
  always_comb begin
    state_d     = state_q;
    pix_req_d   = pix_req_q;
    pix_we_d    = pix_we_q;
    pix_addr_d  = pix_addr_q;
    pix_wdata_d = pix_wdata_q;
    mem_stall   = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        mem_stall = pix_op_s;
        if (pix_op_s) begin
          state_d     = MEM_PIX_BUSY;
          pix_req_d   = 1'b1;
          pix_we_d    = exe_cu.memPixWrite;
          pix_addr_d  = exe_data.aluResult[PIX_AW-1:0];
          pix_wdata_d = exe_data.R1[PIX_DW-1:0];
        end else begin
          state_d = MEM_IDLE;
        end
      end
      MEM_PIX_BUSY: begin
        mem_stall = !pix_ack;
        if (pix_ack) begin
          state_d   = MEM_IDLE;
          pix_req_d = 1'b0;
        end else begin
          state_d = MEM_PIX_BUSY;
        end
      end
      default: begin
        state_d   = MEM_IDLE;
        pix_req_d = 1'b0;
      end
    endcase
  end

  // MEM/WB next values; a stall inserts a bubble and leaves the data fields as they were
  always_comb begin
    wb_valid_d = 1'b0;
    wb_cu_d    = '0;
    alu_d      = alu_q;
    trig_d     = trig_q;
    pix_rd_d   = pix_rd_q;
    if (mem_stall) begin
      wb_valid_d = 1'b0;
      wb_cu_d    = '0;
    end else begin
      wb_valid_d = in_valid;
      alu_d      = exe_data.aluResult;
      trig_d     = exe_data.trigResult;
      pix_rd_d   = ack_s ? {{(XLEN-PIX_DW){1'b0}}, pix_rdata} : {XLEN{1'b0}};
      if (in_valid) begin
        wb_cu_d.regWrite = exe_cu.regWrite;
        wb_cu_d.pcSrc    = exe_cu.pcSrc;
        wb_cu_d.memToReg = exe_cu.memToReg;
      end else begin
        wb_cu_d = '0;
      end
    end
  end

  // state, pixel port and MEM/WB registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MEM_IDLE;
      pix_req_q   <= 1'b0;
      pix_we_q    <= 1'b0;
      pix_addr_q  <= {PIX_AW{1'b0}};
      pix_wdata_q <= {PIX_DW{1'b0}};
      wb_valid_q  <= 1'b0;
      wb_cu_q     <= '0;
      alu_q       <= {XLEN{1'b0}};
      trig_q      <= {XLEN{1'b0}};
      pix_rd_q    <= {XLEN{1'b0}};
    end else begin
      state_q     <= state_d;
      pix_req_q   <= pix_req_d;
      pix_we_q    <= pix_we_d;
      pix_addr_q  <= pix_addr_d;
      pix_wdata_q <= pix_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_cu_q     <= wb_cu_d;
      alu_q       <= alu_d;
      trig_q      <= trig_d;
      pix_rd_q    <= pix_rd_d;
    end
  end

  // A combined RAM+pixel store writes RAM only on the ack edge, when the stall lifts.
  assign dm_we_s = in_valid && exe_cu.memWrite && !mem_stall;

  data_mem #(
    .DEPTH (DMEM_DEPTH),
    .AW    (DM_AW)
  ) u_data_mem (
    .clk     (clk),
    .rst     (rst),
    .re_i    (!mem_stall),
    .we_i    (dm_we_s),
    .addr_i  (exe_data.aluResult[DM_AW-1:0]),
    .wdata_i (exe_data.R1),
    .rdata_o (dm_rdata_s)
  );

  assign pix_req   = pix_req_q;
  assign pix_we    = pix_we_q;
  assign pix_addr  = pix_addr_q;
  assign pix_wdata = pix_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_cu     = wb_cu_q;

  assign wb_data.aluResult   = alu_q;
  assign wb_data.dataMemRead = dm_rdata_s;
  assign wb_data.pixMemRead  = pix_rd_q;
  assign wb_data.trigResult  = trig_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed + randomized bench for mem_stage with a word-array RAM model and
// an inline pixel responder that acks after a chosen number of busy cycles.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  exe_mem_cu_signals exe_cu;
  exe_mem_interface  exe_data;
  logic              mem_stall;
  logic              wb_valid;
  mem_wb_cu_signals  wb_cu;
  mem_wb_interface   wb_data;
  logic              pix_req;
  logic              pix_we;
  logic [18:0]       pix_addr;
  logic [7:0]        pix_wdata;
  logic [7:0]        pix_rdata;
  logic              pix_ack;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [1024];
  bit          known   [1024];

  mem_stage #(.DMEM_DEPTH(1024), .PIX_AW(19), .PIX_DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .exe_cu    (exe_cu),
    .exe_data  (exe_data),
    .mem_stall (mem_stall),
    .wb_valid  (wb_valid),
    .wb_cu     (wb_cu),
    .wb_data   (wb_data),
    .pix_req   (pix_req),
    .pix_we    (pix_we),
    .pix_addr  (pix_addr),
    .pix_wdata (pix_wdata),
    .pix_rdata (pix_rdata),
    .pix_ack   (pix_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exe_mem_cu_signals mk_cu(input logic rw, input logic pc, input logic [1:0] mtr,
                                              input logic mw, input logic mpw);
    exe_mem_cu_signals c;
    c.regWrite = rw; c.pcSrc = pc; c.memToReg = mtr; c.memWrite = mw; c.memPixWrite = mpw;
    return c;
  endfunction

  function automatic exe_mem_interface mk_dat(input logic [31:0] a, input logic [31:0] r1,
                                              input logic [31:0] t);
    exe_mem_interface d;
    d.aluResult = a; d.R1 = r1; d.trigResult = t;
    return d;
  endfunction

  // Presents one instruction, acts as the pixel device (ack after d busy cycles),
  // and checks the MEM/WB result against the RAM model.
  task automatic do_op(input logic v, input exe_mem_cu_signals cu, input exe_mem_interface dat,
                       input int d, input logic [7:0] rd, input logic stray);
    logic        pix;
    logic [9:0]  idx;
    logic [31:0] exp_dm;
    logic [3:0]  exp_cu;
    pix = v && (cu.memPixWrite || cu.memToReg == 2'b10);
    in_valid = v; exe_cu = cu; exe_data = dat;
    pix_ack = pix ? 1'b0 : stray;
    pix_rdata = 8'($urandom);
    #1;
    chk("stall_issue", mem_stall, pix);
    if (pix) begin
      tick();
      chk("pix_req_start", pix_req, 1'b1);
      chk("pix_we", pix_we, cu.memPixWrite);
      chk("pix_addr", pix_addr, dat.aluResult[18:0]);
      chk("pix_wdata", pix_wdata, dat.R1[7:0]);
      chk("wb_bubble_start", wb_valid, 1'b0);
      for (int k = 0; k < d; k++) begin
        chk("stall_busy", mem_stall, 1'b1);
        tick();
        chk("pix_req_held", pix_req, 1'b1);
        chk("pix_addr_held", pix_addr, dat.aluResult[18:0]);
        chk("pix_wdata_held", pix_wdata, dat.R1[7:0]);
        chk("wb_bubble_busy", wb_valid, 1'b0);
      end
      pix_ack = 1'b1;
      pix_rdata = rd;
      #1;
      chk("stall_ack", mem_stall, 1'b0);
    end
    idx = dat.aluResult[9:0];
    exp_dm = ref_mem[idx];
    tick();
    pix_ack = 1'b0;
    exp_cu = v ? {cu.regWrite, cu.pcSrc, cu.memToReg} : 4'd0;
    chk("wb_valid", wb_valid, v);
    chk("wb_cu", wb_cu, exp_cu);
    chk("pix_req_done", pix_req, 1'b0);
    if (v) begin
      chk("wb_alu", wb_data.aluResult, dat.aluResult);
      chk("wb_trig", wb_data.trigResult, dat.trigResult);
      chk("wb_pix", wb_data.pixMemRead, pix ? {24'd0, rd} : 32'd0);
      if (known[idx]) chk("wb_dmem", wb_data.dataMemRead, exp_dm);
      if (cu.memWrite) begin
        ref_mem[idx] = dat.R1;
        known[idx] = 1'b1;
      end
    end
  endtask

  initial begin
    int kind, d;
    logic v, pc, stray;
    logic [1:0] mtr;
    logic [31:0] a;
    exe_mem_cu_signals cu;

    for (int i = 0; i < 1024; i++) begin ref_mem[i] = 32'd0; known[i] = 1'b0; end
    rst = 1'b1; in_valid = 1'b0; pix_ack = 1'b0; pix_rdata = 8'd0;
    exe_cu = mk_cu(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    exe_data = mk_dat(32'd0, 32'd0, 32'd0);
    #1;
    chk("rst_pix_req", pix_req, 1'b0);
    chk("rst_pix_we", pix_we, 1'b0);
    chk("rst_pix_addr", pix_addr, 19'd0);
    chk("rst_pix_wdata", pix_wdata, 8'd0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_cu", wb_cu, 4'd0);
    chk("rst_wb_data", wb_data, 128'd0);
    chk("rst_stall", mem_stall, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // store then load the same word
    do_op(1'b1, mk_cu(1'b0, 1'b0, MTR_ALU, 1'b1, 1'b0), mk_dat(32'h10, 32'hDEADBEEF, 32'h1), 0, 8'd0, 1'b0);
    do_op(1'b1, mk_cu(1'b1, 1'b0, MTR_DMEM, 1'b0, 1'b0), mk_dat(32'h10, 32'h0, 32'h2), 0, 8'd0, 1'b0);
    chk("t1_load", wb_data.dataMemRead, 32'hDEADBEEF);

    // pixel write acked in the third busy cycle, then pixel read with immediate ack
    do_op(1'b1, mk_cu(1'b0, 1'b0, MTR_ALU, 1'b0, 1'b1), mk_dat(32'h123, 32'hAB, 32'h3), 2, 8'h00, 1'b0);
    do_op(1'b0, mk_cu(1'b0, 1'b0, MTR_ALU, 1'b0, 1'b0), mk_dat(32'h0, 32'h0, 32'h0), 0, 8'h00, 1'b0);
    do_op(1'b1, mk_cu(1'b1, 1'b0, MTR_PIX, 1'b0, 1'b0), mk_dat(32'h456, 32'h0, 32'h4), 0, 8'h5A, 1'b0);
    chk("t3_pixread", wb_data.pixMemRead, 32'h0000005A);
    chk("t3_mtr", wb_cu.memToReg, 2'b10);

    // combined RAM+pixel store: dataMemRead at the ack edge must still show the old word
    do_op(1'b1, mk_cu(1'b0, 1'b0, MTR_ALU, 1'b1, 1'b0), mk_dat(32'h4, 32'h11112222, 32'h0), 0, 8'd0, 1'b0);
    do_op(1'b1, mk_cu(1'b0, 1'b0, MTR_ALU, 1'b1, 1'b1), mk_dat(32'h4, 32'hCAFEF00D, 32'h0), 2, 8'd0, 1'b0);
    chk("t4_old_at_ack", wb_data.dataMemRead, 32'h11112222);
    do_op(1'b1, mk_cu(1'b1, 1'b0, MTR_DMEM, 1'b0, 1'b0), mk_dat(32'h4, 32'h0, 32'h0), 0, 8'd0, 1'b0);
    chk("t4_load", wb_data.dataMemRead, 32'hCAFEF00D);

    // address wrap modulo depth
    do_op(1'b1, mk_cu(1'b0, 1'b0, MTR_ALU, 1'b1, 1'b0), mk_dat(32'h404, 32'h600DD00D, 32'h0), 0, 8'd0, 1'b0);
    do_op(1'b1, mk_cu(1'b1, 1'b0, MTR_DMEM, 1'b0, 1'b0), mk_dat(32'h4, 32'h0, 32'h0), 0, 8'd0, 1'b0);
    chk("t6_wrap", wb_data.dataMemRead, 32'h600DD00D);

    // reset in the middle of a pixel access, then a stray ack
    in_valid = 1'b1;
    exe_cu = mk_cu(1'b0, 1'b0, MTR_ALU, 1'b0, 1'b1);
    exe_data = mk_dat(32'h77, 32'h33, 32'h0);
    #1;
    tick();
    chk("t5_busy_req", pix_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_req", pix_req, 1'b0);
    chk("t5_rst_wbv", wb_valid, 1'b0);
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    pix_ack = 1'b1; pix_rdata = 8'hEE;
    #1;
    chk("t5_stray_stall", mem_stall, 1'b0);
    tick();
    pix_ack = 1'b0;
    chk("t5_stray_req", pix_req, 1'b0);
    chk("t5_stray_wbv", wb_valid, 1'b0);
    chk("t5_stray_pix", wb_data.pixMemRead, 32'd0);

    // preload a small window so random loads have known data, then random traffic
    for (int i = 0; i < 32; i++)
      do_op(1'b1, mk_cu(1'b0, 1'b0, MTR_ALU, 1'b1, 1'b0), mk_dat(i, $urandom, 32'd0), 0, 8'd0, 1'b0);
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 5);
      v = ($urandom_range(0, 7) != 0);
      pc = 1'($urandom);
      stray = 1'($urandom);
      d = $urandom_range(0, 3);
      a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 31));
      mtr = $urandom_range(0, 1) ? MTR_TRIG : MTR_ALU;
      case (kind)
        0: cu = mk_cu(1'b1, pc, mtr, 1'b0, 1'b0);
        1: cu = mk_cu(1'b0, pc, MTR_ALU, 1'b1, 1'b0);
        2: cu = mk_cu(1'b1, pc, MTR_DMEM, 1'b0, 1'b0);
        3: cu = mk_cu(1'b0, pc, MTR_ALU, 1'b0, 1'b1);
        4: cu = mk_cu(1'b1, pc, MTR_PIX, 1'b0, 1'b0);
        default: cu = mk_cu(1'b0, pc, MTR_ALU, 1'b1, 1'b1);
      endcase
      do_op(v, cu, mk_dat(a, $urandom, $urandom), d, 8'($urandom), stray);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
